// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB arbitrating master.
// Holds the transfer FSM states and the default bus geometry.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_arb_master_if.sv
// APB bus bundle between the arbitrating master and its memory slave.
// PREADY/PRDATA flow slave-to-master, everything else master-to-slave.
interface apb_arb_master_if
  import apb_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEF_DEPTH)
) ();

  logic             PSELx;
  logic             PENABLE;
  logic             PWRITE;
  logic [AW-1:0]    PADDR;
  logic [WIDTH-1:0] PWDATA;
  logic             PREADY;
  logic [WIDTH-1:0] PRDATA;

  modport master (
    output PSELx,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    input  PREADY,
    input  PRDATA
  );

  modport slave (
    input  PSELx,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    output PREADY,
    output PRDATA
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant. The priority pointer only moves when a grant
// is actually taken, so an idle or withdrawn request never shifts fairness.
module apb_rr_arbiter (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  // Requester that wins when both are pending; 0 out of reset.
  logic r_prio;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_prio ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_prio <= 1'b0;
    end else if (i_accept) begin
      r_prio <= ~o_grant[1];
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters: round-robin pick in IDLE, one
// SETUP/ACCESS transfer at a time, one-cycle completion pulse per requester.
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              PCLK,
  input  logic              PRESETn,

  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [AW-1:0]     req0_addr,
  input  logic [WIDTH-1:0]  req0_wdata,
  output logic              req0_ready,

  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [AW-1:0]     req1_addr,
  input  logic [WIDTH-1:0]  req1_wdata,
  output logic              req1_ready,

  output logic              resp0_valid,
  output logic [WIDTH-1:0]  resp0_rdata,
  output logic              resp0_err,

  output logic              resp1_valid,
  output logic [WIDTH-1:0]  resp1_rdata,
  output logic              resp1_err,

  apb_arb_master_if.master  apb
);

  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e       r_state;
  apb_state_e       w_state_next;
  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_done;
  logic             w_timeout;

  logic [CW-1:0]    r_cnt;
  logic             r_id;
  logic             r_write;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;

  logic [1:0]       r_resp_valid;
  logic [WIDTH-1:0] r_resp_rdata;
  logic             r_resp_err;

  apb_rr_arbiter u_arb (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .i_req    ({req1_valid, req0_valid}),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PRESETn gates acceptance so ready stays low while reset is asserted.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (PRESETn && (w_grant != 2'b00)) begin
          w_accept     = 1'b1;
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        w_state_next = ACCESS;
      end
      ACCESS: begin
        if (apb.PREADY) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign req0_ready = w_accept & w_grant[0];
  assign req1_ready = w_accept & w_grant[1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_id    <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_id    <= w_grant[1];
      r_write <= w_grant[1] ? req1_write : req0_write;
      r_addr  <= w_grant[1] ? req1_addr  : req0_addr;
      r_wdata <= w_grant[1] ? req1_wdata : req0_wdata;
    end
  end

  // Counts completed ACCESS cycles of the current transfer only.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_resp_valid <= 2'b00;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= {r_id, ~r_id} & {2{w_done | w_timeout}};
      r_resp_rdata <= (w_done && !r_write) ? apb.PRDATA : '0;
      r_resp_err   <= w_timeout;
    end
  end

  assign resp0_valid = r_resp_valid[0];
  assign resp0_rdata = r_resp_valid[0] ? r_resp_rdata : '0;
  assign resp0_err   = r_resp_valid[0] & r_resp_err;
  assign resp1_valid = r_resp_valid[1];
  assign resp1_rdata = r_resp_valid[1] ? r_resp_rdata : '0;
  assign resp1_err   = r_resp_valid[1] & r_resp_err;

  assign apb.PSELx   = (r_state != IDLE);
  assign apb.PENABLE = (r_state == ACCESS);
  assign apb.PWRITE  = r_write;
  assign apb.PADDR   = r_addr;
  assign apb.PWDATA  = r_wdata;

endmodule
